glb_weight_banked: RTL
======================

Name: glb_weight_banked

Overview:
- Multi-bank weight global buffer between off-chip weight load and the PE-array weight scratchpads.
- Parametrised generalisation of the single-bank weight GLB: NUM_BANKS independent synchronous SRAM banks.
- Single-word or broadcast writes.
- Autonomous burst-read engine that streams a contiguous weight run from one bank over a valid/ready interface with full throughput and lossless backpressure.

Parameters:
- DATA_BITWIDTH, 16, weight word width.
- ADDR_BITWIDTH, 10, per-bank address width; bank depth = 2^ADDR_BITWIDTH.
- NUM_BANKS, 4, number of banks (power of two, >=1).
- BANK_BITS, $clog2(NUM_BANKS) (min 1), bank-select width; derived, not overridden.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset (asserted when 0).
- w_en  input  1  write strobe.
- w_broadcast  input  1  when set with w_en, write w_data to w_addr in every bank.
- w_bank  input  BANK_BITS  target bank for non-broadcast writes.
- w_addr  input  ADDR_BITWIDTH  write address.
- w_data  input  DATA_BITWIDTH  write data.
- rd_start  input  1  burst request pulse.
- rd_bank  input  BANK_BITS  burst source bank.
- rd_base  input  ADDR_BITWIDTH  burst start address.
- rd_len  input  ADDR_BITWIDTH+1  burst length in words, 1..2^ADDR_BITWIDTH.
- rd_busy  output  1  burst in progress; rd_start ignored while high.
- r_valid  output  1  r_data valid.
- r_ready  input  1  consumer accepts word.
- r_data  output  DATA_BITWIDTH  streamed weight.
- r_last  output  1  marks final word of burst.

Behaviour:
- Reset (reset=0, asynchronous):
  - FSM to IDLE; rd_busy=0, r_valid=0, r_last=0, r_data=0.
  - Output FIFO emptied; address and remaining counters cleared.
  - Memory contents are not reset.
  - Reset mid-burst aborts the burst; no further words are emitted.
- Writes:
  - Synchronous on clk when w_en=1 and reset deasserted.
  - w_broadcast=1: all banks written, w_bank ignored. Otherwise only bank w_bank.
  - w_bank >= NUM_BANKS (non-power-of-two configurations are illegal): write dropped.
- FSM states: IDLE, BURST, DRAIN.
  - IDLE: rd_start=1 and rd_len!=0 latches bank, base and remaining=rd_len; goes to BURST; rd_busy=1 from the next cycle.
  - IDLE: rd_start with rd_len=0 is ignored.
  - BURST: issues one SRAM read per cycle when (FIFO occupancy + reads in flight) < 2.
    - Each issue increments the address modulo 2^ADDR_BITWIDTH, so the address wraps from max to 0, and decrements remaining.
    - When the last read issues, go to DRAIN.
  - DRAIN: wait until the final word is handshaken (r_valid & r_ready & r_last), then go to IDLE; rd_busy falls the following cycle.
  - rd_start while rd_busy=1 is ignored (no queueing).
- Read latency and throughput:
  - rd_start accepted at edge N; first SRAM read issued in cycle N+1; r_valid=1 in cycle N+2.
  - With r_ready held high: one word per cycle; r_last asserts in cycle N+1+rd_len.
- Backpressure:
  - 2-entry output FIFO; no word is lost or duplicated.
  - r_data and r_last remain stable while r_valid=1 and r_ready=0.
  - r_data=0 whenever r_valid=0.
- r_last is carried with its word through the FIFO.
- Read/write collision (same bank, same address, same cycle): read-first; the streamed word is the old contents. The write still completes.
- A write to a bank during a burst from that bank is legal. Later burst addresses see the new data.

Test Plan:
- Write bank1 addr 0..7 with 0x100+i, others unwritten; burst bank1 base 0 len 8, r_ready=1 -> r_valid from start+2, data 0x100..0x107 on consecutive cycles, r_last only on 0x107, rd_busy low after.
- Broadcast write addr 5 = 0xBEEF; burst each bank base 5 len 1 -> every bank returns 0xBEEF with r_last=1.
- Burst base 1022 len 4, ADDR_BITWIDTH=10 -> words from addresses 1022, 1023, 0, 1 in order.
- Burst len 8 with r_ready toggled 1,0,0,1,0,1... -> exactly 8 handshakes, correct order, r_data stable while stalled, no gaps once r_ready is held high.
- Same-cycle write 0x2222 to bank0 addr 3 (old value 0x1111) as the burst reads addr 3 -> stream shows 0x1111; a later burst shows 0x2222.
- Assert reset mid-burst after 3 words -> r_valid, rd_busy, r_data go 0 immediately; after release, a new burst streams correct data; rd_start while busy and rd_len=0 are both ignored.

Source files
------------

// File: rtl/glb_weight_banked_if.sv
`default_nettype none
// ============================================================================
//  Module   : glb_weight_banked_if
//  Purpose  : Bundles the write bus, the burst-request bus and the streamed
//             read channel of the banked weight global buffer.
//  Ports    : w_en/w_broadcast/w_bank/w_addr/w_data  - word/broadcast write
//             rd_start/rd_bank/rd_base/rd_len/rd_busy - burst request
//             r_valid/r_ready/r_data/r_last           - valid/ready stream
//  Modports : master (loader + consumer side), slave (buffer side)
//  Revision : 1.0 - initial release
// ============================================================================
interface glb_weight_banked_if #(
    parameter int DATA_BITWIDTH = 16,
    parameter int ADDR_BITWIDTH = 10,
    parameter int NUM_BANKS     = 4
);
    localparam int BANK_BITS = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;

    logic                     w_en;
    logic                     w_broadcast;
    logic [BANK_BITS-1:0]     w_bank;
    logic [ADDR_BITWIDTH-1:0] w_addr;
    logic [DATA_BITWIDTH-1:0] w_data;

    logic                     rd_start;
    logic [BANK_BITS-1:0]     rd_bank;
    logic [ADDR_BITWIDTH-1:0] rd_base;
    logic [ADDR_BITWIDTH:0]   rd_len;
    logic                     rd_busy;

    logic                     r_valid;
    logic                     r_ready;
    logic [DATA_BITWIDTH-1:0] r_data;
    logic                     r_last;

    modport master (
        output w_en, w_broadcast, w_bank, w_addr, w_data,
        output rd_start, rd_bank, rd_base, rd_len,
        input  rd_busy,
        input  r_valid, r_data, r_last,
        output r_ready
    );

    modport slave (
        input  w_en, w_broadcast, w_bank, w_addr, w_data,
        input  rd_start, rd_bank, rd_base, rd_len,
        output rd_busy,
        output r_valid, r_data, r_last,
        input  r_ready
    );
endinterface
`default_nettype wire

// File: rtl/glb_weight_banked.sv
`default_nettype none
// ============================================================================
//  Module   : glb_weight_banked
//  Purpose  : Multi-bank weight global buffer. NUM_BANKS synchronous SRAM
//             banks with single-bank or broadcast writes, and a burst-read
//             engine streaming a contiguous (wrapping) run from one bank over
//             a valid/ready channel through a 2-entry output FIFO.
//  Ports    : clk   - rising-edge clock
//             reset - asynchronous, active-low reset
//             bus   - glb_weight_banked_if.slave (write, burst, stream)
//  Revision : 1.0 - initial release
// ============================================================================
module glb_weight_banked #(
    parameter int DATA_BITWIDTH = 16,
    parameter int ADDR_BITWIDTH = 10,
    parameter int NUM_BANKS     = 4
) (
    input  logic               clk,
    input  logic               reset,
    glb_weight_banked_if.slave bus
);
    localparam int BANK_BITS = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
    localparam int DEPTH     = 1 << ADDR_BITWIDTH;

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_BURST = 2'd1;
    localparam logic [1:0] c_DRAIN = 2'd2;

    localparam logic [ADDR_BITWIDTH:0] c_REM_ONE = (ADDR_BITWIDTH+1)'(1);

    // burst engine state
    logic [1:0]               state_q, state_d;
    logic [BANK_BITS-1:0]     bank_q, bank_d;
    logic [ADDR_BITWIDTH-1:0] addr_q, addr_d;
    logic [ADDR_BITWIDTH:0]   remain_q, remain_d;

    // read pipeline / output FIFO
    logic                     inflight_q;
    logic                     inflight_last_q;
    logic [DATA_BITWIDTH-1:0] fifo_data_q [2];
    logic                     fifo_last_q [2];
    logic                     fifo_rd_q;
    logic                     fifo_wr_q;
    logic [1:0]               fifo_cnt_q;

    logic                     w_issue;
    logic                     w_busy;
    logic                     w_push;
    logic                     w_pop;
    logic                     w_fifo_empty;
    logic                     w_valid;
    logic                     w_head_last;
    logic [DATA_BITWIDTH-1:0] w_head_data;
    logic [DATA_BITWIDTH-1:0] w_sram_data;
    logic [DATA_BITWIDTH-1:0] w_bank_rdata [NUM_BANKS];

    // ------------------------------------------------------------------------
    // SRAM banks. Read and write share one process with non-blocking
    // assignments, so a same-address collision returns the old word.
    // ------------------------------------------------------------------------
    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        logic [DATA_BITWIDTH-1:0] mem_q [DEPTH];
        logic [DATA_BITWIDTH-1:0] rdata_q;
        logic                     w_we;
        logic                     w_re;

        // An out-of-range w_bank never matches any bank, so the write drops.
        assign w_we = bus.w_en && (bus.w_broadcast || (bus.w_bank == BANK_BITS'(b)));
        assign w_re = w_issue && (bank_q == BANK_BITS'(b));

        always_ff @(posedge clk) begin
            if (w_we) begin
                mem_q[bus.w_addr] <= bus.w_data;
            end
            if (w_re) begin
                rdata_q <= mem_q[addr_q];
            end
        end

        assign w_bank_rdata[b] = rdata_q;
    end

    always_comb begin
        w_sram_data = '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            if (bank_q == BANK_BITS'(b)) begin
                w_sram_data = w_bank_rdata[b];
            end
        end
    end

    // ------------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= c_IDLE;
            bank_q   <= '0;
            addr_q   <= '0;
            remain_q <= '0;
        end else begin
            state_q  <= state_d;
            bank_q   <= bank_d;
            addr_q   <= addr_d;
            remain_q <= remain_d;
        end
    end

    // ------------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        bank_d   = bank_q;
        addr_d   = addr_q;
        remain_d = remain_q;
        case (state_q)
            c_IDLE: begin
                if (bus.rd_start && (bus.rd_len != '0)) begin
                    state_d  = c_BURST;
                    bank_d   = bus.rd_bank;
                    addr_d   = bus.rd_base;
                    remain_d = bus.rd_len;
                end
            end
            c_BURST: begin
                if (w_issue) begin
                    addr_d   = addr_q + 1'b1;   // wraps at the top of the bank
                    remain_d = remain_q - 1'b1;
                    if (remain_q == c_REM_ONE) begin
                        state_d = c_DRAIN;
                    end
                end
            end
            c_DRAIN: begin
                if (w_valid && bus.r_ready && w_head_last) begin
                    state_d = c_IDLE;
                end
            end
            default: state_d = c_IDLE;
        endcase
    end

    // ------------------------------------------------------------------------
    // FSM: outputs. A read issues only while the FIFO plus the word still in
    // the SRAM register leave room, so the FIFO can never overflow.
    // ------------------------------------------------------------------------
    always_comb begin
        w_busy  = (state_q != c_IDLE);
        w_issue = (state_q == c_BURST) &&
                  ((fifo_cnt_q + {1'b0, inflight_q}) < 2'd2);
    end

    // ------------------------------------------------------------------------
    // Output stream. When the FIFO is empty the SRAM register feeds the port
    // directly (first word two cycles after the request); a word that is not
    // taken that cycle moves into the FIFO unchanged, keeping r_data stable.
    // ------------------------------------------------------------------------
    always_comb begin
        w_fifo_empty = (fifo_cnt_q == 2'd0);
        w_valid      = !w_fifo_empty || inflight_q;
        w_head_data  = w_fifo_empty ? w_sram_data     : fifo_data_q[fifo_rd_q];
        w_head_last  = w_fifo_empty ? inflight_last_q : fifo_last_q[fifo_rd_q];
        w_pop        = !w_fifo_empty && bus.r_ready;
        w_push       = inflight_q && !(w_fifo_empty && bus.r_ready);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
            fifo_data_q[0]  <= '0;
            fifo_data_q[1]  <= '0;
            fifo_last_q[0]  <= 1'b0;
            fifo_last_q[1]  <= 1'b0;
            fifo_rd_q       <= 1'b0;
            fifo_wr_q       <= 1'b0;
            fifo_cnt_q      <= 2'd0;
        end else begin
            inflight_q      <= w_issue;
            inflight_last_q <= w_issue && (remain_q == c_REM_ONE);
            if (w_push) begin
                fifo_data_q[fifo_wr_q] <= w_sram_data;
                fifo_last_q[fifo_wr_q] <= inflight_last_q;
                fifo_wr_q              <= ~fifo_wr_q;
            end
            if (w_pop) begin
                fifo_rd_q <= ~fifo_rd_q;
            end
            case ({w_push, w_pop})
                2'b10:   fifo_cnt_q <= fifo_cnt_q + 2'd1;
                2'b01:   fifo_cnt_q <= fifo_cnt_q - 2'd1;
                default: fifo_cnt_q <= fifo_cnt_q;
            endcase
        end
    end

    assign bus.rd_busy = w_busy;
    assign bus.r_valid = w_valid;
    assign bus.r_data  = w_valid ? w_head_data : '0;
    assign bus.r_last  = w_valid && w_head_last;

endmodule
`default_nettype wire
